// File: rtl/mult_div_unit_if.sv
// rtl/mult_div_unit_if.sv - request/result bundle between EX and the mult/div engine
//
// Signals:
//   start   request strobe from EX, sampled by the engine only when idle
//   op      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a, b    rs / rt operands
//   cancel  abort the in-flight operation (exception or flush)
//   busy    engine is working or presenting its result
//   p       64-bit result {Hi, Lo}
//   is_mult result came from a multiply
//   wen     one-cycle Lo/Hi write strobe, also the done indication
// master = EX side, slave = the engine.

interface mult_div_unit_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        cancel;
    logic        busy;
    logic [63:0] p;
    logic        is_mult;
    logic        wen;

    modport master (
        output start, op, a, b, cancel,
        input  busy, p, is_mult, wen
    );

    modport slave (
        input  start, op, a, b, cancel,
        output busy, p, is_mult, wen
    );
endinterface

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative 32-bit multiply/divide engine feeding the Lo/Hi register
//
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    mult_div_unit_if.slave (start/op/a/b/cancel in; busy/p/is_mult/wen out)
//
// Fixed schedule from the accepting edge T0: 32 iterations on T0+1..T0+32,
// sign fix and result register on T0+33, wen high for the cycle after that.

module mult_div_unit (
    input  logic            clk,
    input  logic            rst_n,
    mult_div_unit_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t      state_q,   state_d;
    logic [5:0]  cnt_q,     cnt_d;
    // Multiply: running product. Divide: {remainder, dividend/quotient}.
    logic [63:0] acc_q,     acc_d;
    // Multiply only: multiplicand magnitude, shifted left each iteration.
    logic [63:0] mcand_q,   mcand_d;
    // Multiply: multiplier magnitude shifted right. Divide: divisor magnitude.
    logic [31:0] opb_q,     opb_d;
    logic        mul_op_q,  mul_op_d;
    logic        neg_lo_q,  neg_lo_d;   // product sign, or quotient sign
    logic        neg_hi_q,  neg_hi_d;   // remainder sign
    logic        div0_q,    div0_d;
    logic [63:0] p_q,       p_d;
    logic        is_mult_q, is_mult_d;
    logic        wen_q,     wen_d;
    logic        busy_q,    busy_d;

    logic        signed_op;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [32:0] rem_shift;
    logic        rem_ge;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;

    always_comb begin
        signed_op = ~bus.op[0];
        a_neg     = signed_op & bus.a[31];
        b_neg     = signed_op & bus.b[31];
        a_mag     = a_neg ? (32'd0 - bus.a) : bus.a;
        b_mag     = b_neg ? (32'd0 - bus.b) : bus.b;

        // Restoring-division step: the remainder shifted left with the next
        // dividend bit fits in 33 bits; the true difference always fits in 32.
        rem_shift = {acc_q[63:32], acc_q[31]};
        rem_ge    = rem_shift >= {1'b0, opb_q};

        // Divide-by-zero leaves the quotient at all ones unfixed; the remainder
        // holds |a| and re-applying a's sign restores a exactly.
        quo_fix   = (neg_lo_q & ~div0_q) ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
        rem_fix   = neg_hi_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];

        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        opb_d     = opb_q;
        mul_op_d  = mul_op_q;
        neg_lo_d  = neg_lo_q;
        neg_hi_d  = neg_hi_q;
        div0_d    = div0_q;
        p_d       = p_q;
        is_mult_d = is_mult_q;
        wen_d     = 1'b0;
        busy_d    = busy_q;

        case (state_q)
            S_IDLE: begin
                // cancel wins over a simultaneous start
                if (bus.start && !bus.cancel) begin
                    mul_op_d = ~bus.op[1];
                    neg_lo_d = a_neg ^ b_neg;
                    neg_hi_d = a_neg;
                    div0_d   = bus.op[1] & (bus.b == 32'd0);
                    opb_d    = b_mag;
                    mcand_d  = {32'd0, a_mag};
                    acc_d    = bus.op[1] ? {32'd0, a_mag} : 64'd0;
                    cnt_d    = 6'd0;
                    busy_d   = 1'b1;
                    state_d  = S_CALC;
                end
            end
            S_CALC: begin
                if (bus.cancel) begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    if (mul_op_q) begin
                        acc_d   = acc_q + (opb_q[0] ? mcand_q : 64'd0);
                        mcand_d = {mcand_q[62:0], 1'b0};
                        opb_d   = {1'b0, opb_q[31:1]};
                    end else begin
                        acc_d[63:32] = rem_ge ? (rem_shift[31:0] - opb_q) : rem_shift[31:0];
                        acc_d[31:0]  = {acc_q[30:0], rem_ge};
                    end
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q == 6'd31) begin
                        state_d = S_FIX;
                    end
                end
            end
            S_FIX: begin
                if (bus.cancel) begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    if (mul_op_q) begin
                        p_d = neg_lo_q ? (64'd0 - acc_q) : acc_q;
                    end else begin
                        p_d = {rem_fix, quo_fix};
                    end
                    is_mult_d = mul_op_q;
                    wen_d     = 1'b1;
                    state_d   = S_DONE;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= 6'd0;
            acc_q     <= 64'd0;
            mcand_q   <= 64'd0;
            opb_q     <= 32'd0;
            mul_op_q  <= 1'b0;
            neg_lo_q  <= 1'b0;
            neg_hi_q  <= 1'b0;
            div0_q    <= 1'b0;
            p_q       <= 64'd0;
            is_mult_q <= 1'b0;
            wen_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            opb_q     <= opb_d;
            mul_op_q  <= mul_op_d;
            neg_lo_q  <= neg_lo_d;
            neg_hi_q  <= neg_hi_d;
            div0_q    <= div0_d;
            p_q       <= p_d;
            is_mult_q <= is_mult_d;
            wen_q     <= wen_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.p       = p_q;
    assign bus.is_mult = is_mult_q;
    assign bus.wen     = wen_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - scoreboard bench for mult_div_unit

module tb_mult_div_unit;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mult_div_unit_if bus();

    mult_div_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] p;
        logic        m;
        int          at;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual %h required %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: plain integer arithmetic on the operands.
    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, sq, sr;
        logic [63:0] ua, ub, uq, ur, res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        res = 64'd0;
        if (op == 2'd0) begin
            res = 64'(sa * sb);
        end else if (op == 2'd1) begin
            res = ua * ub;
        end else if (b == 32'd0) begin
            res = {a, 32'hFFFFFFFF};
        end else if (op == 2'd2) begin
            sq  = sa / sb;
            sr  = sa % sb;
            res = {sr[31:0], sq[31:0]};
        end else begin
            uq  = ua / ub;
            ur  = ua % ub;
            res = {ur[31:0], uq[31:0]};
        end
        return res;
    endfunction

    // Monitor: every wen pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (bus.wen === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_wen actual 1 required 0 (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("p", bus.p, e.p);
                check("is_mult", 64'(bus.is_mult), 64'(e.m));
                check("wen_cycle", 64'(cyc), 64'(e.at));
            end
        end
    end

    task automatic wait_until(input int c);
        do @(negedge clk); while (cyc < c);
    endtask

    // Caller must be at a negedge; start is sampled at the next rising edge.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, output int t0);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(posedge clk);
        #1;
        t0 = cyc;
        bus.start = 1'b0;
        bus.a     = $urandom;
        bus.b     = $urandom;
        check("busy_after_accept", 64'(bus.busy), 64'd1);
    endtask

    task automatic run(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] ep, input logic em);
        int t0;
        issue(op, a, b, t0);
        exp_q.push_back('{p: ep, m: em, at: t0 + 33});
        wait_until(t0 + 34);
        check("busy_idle_after_done", 64'(bus.busy), 64'd0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h00000000;
            1: return 32'h80000000;
            2: return 32'hFFFFFFFF;
            3: return 32'(($urandom_range(0, 15)));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int t0;
        logic [1:0]  rop;
        logic [31:0] ra, rb;

        bus.start  = 1'b0;
        bus.cancel = 1'b0;
        bus.op     = 2'd0;
        bus.a      = 32'd0;
        bus.b      = 32'd0;

        repeat (3) @(negedge clk);
        check("reset_busy", 64'(bus.busy), 64'd0);
        check("reset_wen", 64'(bus.wen), 64'd0);
        check("reset_p", bus.p, 64'd0);
        check("reset_is_mult", 64'(bus.is_mult), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 1'b1);
        run(2'd0, 32'hFFFFFFFD, 32'd7,        64'hFFFFFFFF_FFFFFFEB, 1'b1);
        run(2'd2, 32'hFFFFFFF9, 32'd2,        64'hFFFFFFFF_FFFFFFFD, 1'b0);
        run(2'd3, 32'd100,      32'd7,        {32'd2, 32'd14},       1'b0);
        run(2'd2, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 1'b0);
        run(2'd3, 32'd5,        32'd0,        {32'd5, 32'hFFFFFFFF}, 1'b0);
        run(2'd2, 32'hFFFFFFF9, 32'd0,        {32'hFFFFFFF9, 32'hFFFFFFFF}, 1'b0);

        // Second start during CALC is ignored.
        issue(2'd1, 32'd6, 32'd7, t0);
        exp_q.push_back('{p: 64'd42, m: 1'b1, at: t0 + 33});
        wait_until(t0 + 4);
        bus.start = 1'b1;
        bus.op    = 2'd3;
        bus.a     = 32'd1;
        bus.b     = 32'd1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        wait_until(t0 + 34);

        // Cancel sampled at T0+10, restart sampled at T0+11.
        issue(2'd3, 32'd1000, 32'd3, t0);
        wait_until(t0 + 9);
        bus.cancel = 1'b1;
        @(posedge clk);
        #1 bus.cancel = 1'b0;
        check("cancel_busy", 64'(bus.busy), 64'd0);
        check("cancel_p_kept", bus.p, 64'd42);
        wait_until(t0 + 10);
        run(2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'd1, 1'b1);

        // cancel together with start in IDLE: nothing accepted.
        bus.start  = 1'b1;
        bus.cancel = 1'b1;
        bus.op     = 2'd1;
        bus.a      = 32'd9;
        bus.b      = 32'd9;
        @(posedge clk);
        #1;
        bus.start  = 1'b0;
        bus.cancel = 1'b0;
        check("cancel_start_busy", 64'(bus.busy), 64'd0);
        wait_until(cyc + 40);
        check("cancel_start_p", bus.p, 64'd1);

        // cancel during DONE has no effect on the committed result.
        issue(2'd3, 32'd9, 32'd4, t0);
        exp_q.push_back('{p: {32'd1, 32'd2}, m: 1'b0, at: t0 + 33});
        wait_until(t0 + 33);
        bus.cancel = 1'b1;
        @(posedge clk);
        #1 bus.cancel = 1'b0;
        wait_until(t0 + 34);

        // Reset mid-flight at T0+20.
        issue(2'd1, 32'd3, 32'd5, t0);
        wait_until(t0 + 19);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midreset_busy", 64'(bus.busy), 64'd0);
        check("midreset_wen", 64'(bus.wen), 64'd0);
        check("midreset_p", bus.p, 64'd0);
        rst_n = 1'b1;
        wait_until(t0 + 40);

        // Back-to-back.
        run(2'd1, 32'd2, 32'd3, 64'd6, 1'b1);
        run(2'd3, 32'd9, 32'd4, {32'd1, 32'd2}, 1'b0);

        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = pick();
            rb  = pick();
            run(rop, ra, rb, model(rop, ra, rb), ~rop[1]);
        end

        wait_until(cyc + 5);
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
